// File: rtl/ysyx_bus_arb.sv
// Two-master (IFU read-only, LSU read/write) arbiter onto one AXI-lite style memory port.
// Define YSYX_BUS_ARB_RR_EN for round-robin between IFU and LSU; otherwise LSU has fixed priority.
module ysyx_bus_arb #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDR_W-1:0]   ifu_araddr,
    input  logic                ifu_arvalid,
    output logic [DATA_W-1:0]   ifu_rdata,
    output logic                ifu_rvalid,
    input  logic [ADDR_W-1:0]   lsu_araddr,
    input  logic                lsu_arvalid,
    output logic [DATA_W-1:0]   lsu_rdata,
    output logic                lsu_rvalid,
    input  logic [ADDR_W-1:0]   lsu_awaddr,
    input  logic                lsu_awvalid,
    input  logic [DATA_W-1:0]   lsu_wdata,
    input  logic [DATA_W/8-1:0] lsu_wstrb,
    output logic                lsu_bvalid,
    output logic [ADDR_W-1:0]   mem_araddr,
    output logic                mem_arvalid,
    input  logic                mem_arready,
    input  logic [DATA_W-1:0]   mem_rdata,
    input  logic                mem_rvalid,
    output logic [ADDR_W-1:0]   mem_awaddr,
    output logic                mem_awvalid,
    input  logic                mem_awready,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wstrb,
    output logic                mem_wvalid,
    input  logic                mem_wready,
    input  logic                mem_bvalid
);

    typedef enum logic [2:0] {S_IDLE, S_AR, S_R, S_AW, S_B} state_t;
    typedef enum logic {OWN_LSU = 1'b0, OWN_IFU = 1'b1} owner_t;

    state_t              state;
    owner_t              owner;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W/8-1:0] wstrb_q;
    logic                aw_done;
    logic                w_done;

    logic                lsu_req;
    logic                resp_busy;
    logic                grant_ifu;
    logic                aw_ok;
    logic                w_ok;
    logic [ADDR_W-1:0]   grant_addr;

    assign lsu_req   = lsu_awvalid | lsu_arvalid;
    // Hold off re-arbitration while a response pulse is visible so the master can drop valid.
    assign resp_busy = ifu_rvalid | lsu_rvalid | lsu_bvalid;
    assign aw_ok     = aw_done | (mem_awvalid & mem_awready);
    assign w_ok      = w_done  | (mem_wvalid  & mem_wready);

`ifdef YSYX_BUS_ARB_RR_EN
    assign grant_ifu = ifu_arvalid & (~lsu_req | (owner == OWN_LSU));
`else
    assign grant_ifu = ifu_arvalid & ~lsu_req;
`endif

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        grant_addr = lsu_awvalid ? lsu_awaddr : lsu_araddr;
        if (grant_ifu)
            grant_addr = ifu_araddr;
    end

    // The latched request drives the slave directly, so addresses stay stable while valid.
    assign mem_araddr = addr_q;
    assign mem_awaddr = addr_q;
    assign mem_wdata  = wdata_q;
    assign mem_wstrb  = wstrb_q;

    // NOTE: all state updates are non-blocking so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= S_IDLE;
            owner       <= OWN_LSU;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            aw_done     <= 1'b0;
            w_done      <= 1'b0;
            mem_arvalid <= 1'b0;
            mem_awvalid <= 1'b0;
            mem_wvalid  <= 1'b0;
            ifu_rvalid  <= 1'b0;
            lsu_rvalid  <= 1'b0;
            lsu_bvalid  <= 1'b0;
            ifu_rdata   <= '0;
            lsu_rdata   <= '0;
        end else begin
            ifu_rvalid <= 1'b0;
            lsu_rvalid <= 1'b0;
            lsu_bvalid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (!resp_busy && (ifu_arvalid || lsu_req)) begin
                        addr_q <= grant_addr;
                        owner  <= grant_ifu ? OWN_IFU : OWN_LSU;
                        if (!grant_ifu && lsu_awvalid) begin
                            wdata_q     <= lsu_wdata;
                            wstrb_q     <= lsu_wstrb;
                            aw_done     <= 1'b0;
                            w_done      <= 1'b0;
                            mem_awvalid <= 1'b1;
                            mem_wvalid  <= 1'b1;
                            state       <= S_AW;
                        end else begin
                            mem_arvalid <= 1'b1;
                            state       <= S_AR;
                        end
                    end
                end
                S_AR: begin
                    if (mem_arready) begin
                        mem_arvalid <= 1'b0;
                        state       <= S_R;
                    end
                end
                S_R: begin
                    if (mem_rvalid) begin
                        if (owner == OWN_IFU) begin
                            ifu_rdata  <= mem_rdata;
                            ifu_rvalid <= 1'b1;
                        end else begin
                            lsu_rdata  <= mem_rdata;
                            lsu_rvalid <= 1'b1;
                        end
                        state <= S_IDLE;
                    end
                end
                S_AW: begin
                    aw_done <= aw_ok;
                    w_done  <= w_ok;
                    if (mem_awready)
                        mem_awvalid <= 1'b0;
                    if (mem_wready)
                        mem_wvalid <= 1'b0;
                    if (aw_ok && w_ok)
                        state <= S_B;
                end
                S_B: begin
                    if (mem_bvalid) begin
                        lsu_bvalid <= 1'b1;
                        state      <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_bus_arb.sv
// Scoreboard bench for ysyx_bus_arb: directed masters, a delay-programmable slave model,
// and a monitor that pops expected responses whenever the arbiter pulses a response.
module tb_ysyx_bus_arb;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [AW-1:0] ifu_araddr, lsu_araddr, lsu_awaddr;
    logic          ifu_arvalid, lsu_arvalid, lsu_awvalid;
    logic [DW-1:0] ifu_rdata, lsu_rdata, lsu_wdata;
    logic          ifu_rvalid, lsu_rvalid, lsu_bvalid;
    logic [3:0]    lsu_wstrb, mem_wstrb;
    logic [AW-1:0] mem_araddr, mem_awaddr;
    logic [DW-1:0] mem_rdata, mem_wdata;
    logic          mem_arvalid, mem_arready, mem_rvalid;
    logic          mem_awvalid, mem_awready, mem_wvalid, mem_wready, mem_bvalid;

    always #5 clk = ~clk;

    ysyx_bus_arb #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst),
        .ifu_araddr(ifu_araddr), .ifu_arvalid(ifu_arvalid),
        .ifu_rdata(ifu_rdata), .ifu_rvalid(ifu_rvalid),
        .lsu_araddr(lsu_araddr), .lsu_arvalid(lsu_arvalid),
        .lsu_rdata(lsu_rdata), .lsu_rvalid(lsu_rvalid),
        .lsu_awaddr(lsu_awaddr), .lsu_awvalid(lsu_awvalid),
        .lsu_wdata(lsu_wdata), .lsu_wstrb(lsu_wstrb), .lsu_bvalid(lsu_bvalid),
        .mem_araddr(mem_araddr), .mem_arvalid(mem_arvalid), .mem_arready(mem_arready),
        .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
        .mem_awaddr(mem_awaddr), .mem_awvalid(mem_awvalid), .mem_awready(mem_awready),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_wvalid(mem_wvalid),
        .mem_wready(mem_wready), .mem_bvalid(mem_bvalid)
    );

    // src: 0 = IFU read data, 1 = LSU read data, 2 = LSU write done
    typedef struct {
        int          src;
        logic [31:0] data;
    } resp_t;

    resp_t       exp_resp[$];
    logic [31:0] exp_ar[$];
    logic [31:0] exp_waddr, exp_wdata;
    logic [3:0]  exp_wstrb;
    int          n_cmp = 0;
    int          n_err = 0;
    int          ar_delay = 0, r_delay = 0, aw_delay = 0, w_delay = 0, b_delay = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h8000_0000)
            return 32'h0000_0413;
        return a ^ 32'hA5A5_5A5A;
    endfunction

    function automatic resp_t mk(input int src, input logic [31:0] data);
        resp_t r;
        r.src  = src;
        r.data = data;
        return r;
    endfunction

    // Slave model: sees DUT outputs at negedge, answers for the following posedge.
    initial begin : slave
        int          ar_cnt, r_cnt, aw_cnt, w_cnt, b_cnt;
        bit          r_pend, aw_acc, w_acc;
        logic [31:0] r_addr;
        ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
        r_pend = 0; aw_acc = 0; w_acc = 0; r_addr = '0;
        mem_arready = 0; mem_rvalid = 0; mem_rdata = '0;
        mem_awready = 0; mem_wready = 0; mem_bvalid = 0;
        forever begin
            @(negedge clk);
            mem_rvalid = 0;
            if (r_pend) begin
                if (r_cnt == r_delay) begin
                    mem_rvalid = 1;
                    mem_rdata  = mem_word(r_addr);
                    r_pend     = 0;
                end else r_cnt++;
            end
            mem_arready = 0;
            if (mem_arvalid) begin
                if (exp_ar.size() == 0) begin
                    check("ar_unexpected", {63'd0, mem_arvalid}, 64'd0);
                end else begin
                    check("ar_addr", mem_araddr, exp_ar[0]);
                    if (ar_cnt == ar_delay) begin
                        mem_arready = 1;
                        r_addr = mem_araddr;
                        r_pend = 1;
                        r_cnt  = 0;
                        ar_cnt = 0;
                        void'(exp_ar.pop_front());
                    end else ar_cnt++;
                end
            end else ar_cnt = 0;
            mem_bvalid = 0;
            if (aw_acc && w_acc) begin
                if (b_cnt == b_delay) begin
                    mem_bvalid = 1;
                    aw_acc = 0;
                    w_acc  = 0;
                    b_cnt  = 0;
                end else b_cnt++;
            end
            mem_awready = 0;
            if (mem_awvalid) begin
                if (aw_cnt == aw_delay) begin
                    check("aw_addr", mem_awaddr, exp_waddr);
                    mem_awready = 1;
                    aw_acc = 1;
                    aw_cnt = 0;
                end else aw_cnt++;
            end else aw_cnt = 0;
            mem_wready = 0;
            if (mem_wvalid) begin
                if (w_cnt == w_delay) begin
                    check("w_data", mem_wdata, exp_wdata);
                    check("w_strb", mem_wstrb, exp_wstrb);
                    mem_wready = 1;
                    w_acc = 1;
                    w_cnt = 0;
                end else w_cnt++;
            end else w_cnt = 0;
        end
    end

    task automatic take(input int src, input logic [31:0] data);
        resp_t e;
        if (exp_resp.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL resp_unexpected: src %0d data %h, none expected (t=%0t)", src, data, $time);
        end else begin
            e = exp_resp.pop_front();
            check("resp_src", src, e.src);
            if (src != 2)
                check("resp_data", data, e.data);
        end
    endtask

    // Monitor: every response pulse consumes exactly one scoreboard entry.
    initial begin : monitor
        forever begin
            @(negedge clk);
            if (rst) begin
                if (ifu_rvalid) take(0, ifu_rdata);
                if (lsu_rvalid) take(1, lsu_rdata);
                if (lsu_bvalid) take(2, 32'd0);
            end
        end
    end

    task automatic apply_reset();
        rst = 0;
        repeat (3) @(negedge clk);
        rst = 1;
    endtask

    task automatic ifu_read(input logic [31:0] a);
        bit got;
        got = 0;
        ifu_araddr  = a;
        ifu_arvalid = 1;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            got = ifu_rvalid;
        end
        ifu_arvalid = 0;
        check("ifu_read_done", {63'd0, got}, 64'd1);
    endtask

    task automatic lsu_read(input logic [31:0] a);
        bit got;
        got = 0;
        lsu_araddr  = a;
        lsu_arvalid = 1;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            got = lsu_rvalid;
        end
        lsu_arvalid = 0;
        check("lsu_read_done", {63'd0, got}, 64'd1);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int pulses;
        ifu_araddr = '0; ifu_arvalid = 0;
        lsu_araddr = '0; lsu_arvalid = 0;
        lsu_awaddr = '0; lsu_awvalid = 0; lsu_wdata = '0; lsu_wstrb = '0;
        exp_waddr = '0; exp_wdata = '0; exp_wstrb = '0;

        // Reset state
        apply_reset();
        check("reset_outputs",
              {mem_arvalid, mem_awvalid, mem_wvalid, ifu_rvalid, lsu_rvalid, lsu_bvalid,
               ifu_rdata, lsu_rdata}, 64'd0);

        // IFU only, zero-wait slave: AR in cycle 1, pulse in cycle 3
        exp_ar.push_back(32'h8000_0000);
        exp_resp.push_back(mk(0, 32'h0000_0413));
        ifu_araddr  = 32'h8000_0000;
        ifu_arvalid = 1;
        @(negedge clk);
        check("t1_arvalid_c1", {63'd0, mem_arvalid}, 64'd1);
        @(negedge clk);
        check("t1_arvalid_c2", {63'd0, mem_arvalid}, 64'd0);
        check("t1_rvalid_c2", {63'd0, ifu_rvalid}, 64'd0);
        @(negedge clk);
        check("t1_rvalid_c3", {63'd0, ifu_rvalid}, 64'd1);
        check("t1_rdata_c3", ifu_rdata, 64'h0000_0413);
        check("t1_lsu_rvalid_c3", {63'd0, lsu_rvalid}, 64'd0);
        ifu_arvalid = 0;
        @(negedge clk);
        check("t1_rvalid_c4", {63'd0, ifu_rvalid}, 64'd0);
        repeat (3) @(negedge clk);

        // Same-cycle IFU and LSU reads from a fresh reset (owner = LSU)
        apply_reset();
`ifdef YSYX_BUS_ARB_RR_EN
        exp_ar.push_back(32'h8000_0004);
        exp_ar.push_back(32'h8000_1000);
        exp_resp.push_back(mk(0, mem_word(32'h8000_0004)));
        exp_resp.push_back(mk(1, mem_word(32'h8000_1000)));
`else
        exp_ar.push_back(32'h8000_1000);
        exp_ar.push_back(32'h8000_0004);
        exp_resp.push_back(mk(1, mem_word(32'h8000_1000)));
        exp_resp.push_back(mk(0, mem_word(32'h8000_0004)));
`endif
        fork
            ifu_read(32'h8000_0004);
            lsu_read(32'h8000_1000);
        join
        repeat (3) @(negedge clk);

        // LSU write, awready two cycles ahead of wready
        aw_delay = 0; w_delay = 2; b_delay = 0;
        exp_waddr = 32'h8000_2000; exp_wdata = 32'hDEAD_BEEF; exp_wstrb = 4'hF;
        exp_resp.push_back(mk(2, 32'd0));
        lsu_awaddr = 32'h8000_2000; lsu_wdata = 32'hDEAD_BEEF; lsu_wstrb = 4'hF;
        lsu_awvalid = 1;
        @(negedge clk);
        check("t3_valids_c1", {62'd0, mem_awvalid, mem_wvalid}, 64'd3);
        lsu_awaddr = 32'h1111_1111; lsu_wdata = 32'h2222_2222; lsu_wstrb = 4'h1;
        @(negedge clk);
        check("t3_valids_c2", {62'd0, mem_awvalid, mem_wvalid}, 64'd1);
        @(negedge clk);
        check("t3_valids_c3", {62'd0, mem_awvalid, mem_wvalid}, 64'd1);
        @(negedge clk);
        check("t3_valids_c4", {61'd0, mem_awvalid, mem_wvalid, lsu_bvalid}, 64'd0);
        @(negedge clk);
        check("t3_bvalid_c5", {63'd0, lsu_bvalid}, 64'd1);
        lsu_awvalid = 0;
        @(negedge clk);
        check("t3_bvalid_c6", {63'd0, lsu_bvalid}, 64'd0);
        w_delay = 0;
        repeat (3) @(negedge clk);

        // Slow slave: address must stay stable, exactly one pulse
        ar_delay = 5; r_delay = 3;
        exp_ar.push_back(32'h8000_0010);
        exp_resp.push_back(mk(0, mem_word(32'h8000_0010)));
        ifu_araddr  = 32'h8000_0010;
        ifu_arvalid = 1;
        pulses = 0;
        @(negedge clk);
        ifu_araddr = 32'h1234_5678;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (ifu_rvalid) begin
                pulses++;
                ifu_arvalid = 0;
            end
        end
        check("t4_pulses", pulses, 1);
        ar_delay = 0; r_delay = 0;

        // Reset while in R abandons the read; the late mem_rvalid is ignored
        r_delay = 4;
        exp_ar.push_back(32'h8000_0020);
        ifu_araddr  = 32'h8000_0020;
        ifu_arvalid = 1;
        @(negedge clk);
        @(negedge clk);
        check("t5_in_r_arvalid", {63'd0, mem_arvalid}, 64'd0);
        rst = 0;
        ifu_arvalid = 0;
        @(negedge clk);
        check("t5_after_reset",
              {58'd0, mem_arvalid, mem_awvalid, mem_wvalid, ifu_rvalid, lsu_rvalid, lsu_bvalid}, 64'd0);
        rst = 1;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (ifu_rvalid || lsu_rvalid) pulses++;
        end
        check("t5_no_pulse", pulses, 0);
        r_delay = 0;

        // IFU valid held high: three transactions, one pulse each
        for (int i = 0; i < 3; i++) begin
            exp_ar.push_back(32'h8000_0040);
            exp_resp.push_back(mk(0, mem_word(32'h8000_0040)));
        end
        ifu_araddr  = 32'h8000_0040;
        ifu_arvalid = 1;
        pulses = 0;
        for (int i = 0; i < 60 && pulses < 3; i++) begin
            @(negedge clk);
            if (ifu_rvalid) pulses++;
        end
        ifu_arvalid = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (ifu_rvalid) pulses++;
        end
        check("t6_pulses", pulses, 3);

        check("exp_resp_left", exp_resp.size(), 0);
        check("exp_ar_left", exp_ar.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ysyx_bus_arb.md
Name: ysyx_bus_arb

Overview:
Two-master, one-slave arbiter sharing the core's single memory port between IFU instruction fetch (read-only) and LSU load/store. Sits between ysyx_IFU/ysyx_LSU and the memory/crossbar. Sequences one transaction at a time through an AR/R or AW+W/B FSM and routes responses to the granted master. Masters hold valid as a level until they see their one-cycle response pulse.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-low reset
ifu_araddr  in  ADDR_W  IFU read address
ifu_arvalid  in  1  IFU read request (level, held until ifu_rvalid)
ifu_rdata  out  DATA_W  IFU read data
ifu_rvalid  out  1  IFU data pulse, 1 cycle
lsu_araddr  in  ADDR_W  LSU read address
lsu_arvalid  in  1  LSU read request (level)
lsu_rdata  out  DATA_W  LSU read data
lsu_rvalid  out  1  LSU read-data pulse
lsu_awaddr  in  ADDR_W  LSU write address
lsu_awvalid  in  1  LSU write request (level)
lsu_wdata  in  DATA_W  LSU write data
lsu_wstrb  in  DATA_W/8  byte strobes
lsu_bvalid  out  1  LSU write-done pulse
mem_araddr  out  ADDR_W  slave read address
mem_arvalid  out  1  slave read request
mem_arready  in  1  slave accepts AR
mem_rdata  in  DATA_W  slave read data
mem_rvalid  in  1  slave read data valid
mem_awaddr  out  ADDR_W  slave write address
mem_awvalid  out  1  slave write address valid
mem_awready  in  1  slave accepts AW
mem_wdata  out  DATA_W  slave write data
mem_wstrb  out  DATA_W/8  slave strobes
mem_wvalid  out  1  slave write data valid
mem_wready  in  1  slave accepts W
mem_bvalid  in  1  slave write response

Behaviour:
- States: IDLE, AR, R, AW, B. Registers: state, owner (IFU/LSU), latched addr/wdata/wstrb, aw_done, w_done.
- Reset (rst==0 at posedge): state=IDLE, owner=LSU, all mem_*valid=0, ifu_rvalid=lsu_rvalid=lsu_bvalid=0, rdata outputs 0. Reset mid-transaction abandons it; stray mem_rvalid/mem_bvalid in IDLE ignored.
- IDLE grant (fixed priority): lsu_awvalid > lsu_arvalid > ifu_arvalid. Grant latches address (and wdata/wstrb); next state AW for write, AR for read. No request: stay IDLE.
- AR: mem_arvalid=1, mem_araddr=latched. On mem_arready -> R, mem_arvalid drops next cycle.
- R: on mem_rvalid, registered rdata to owner, owner's rvalid high exactly 1 cycle (the cycle after mem_rvalid); -> IDLE. Other master's rvalid stays 0.
- AW: mem_awvalid and mem_wvalid asserted together; each drops independently once its ready seen (aw_done/w_done). Both done -> B. AW and W accepted same cycle -> B directly.
- B: on mem_bvalid, lsu_bvalid pulses 1 cycle; -> IDLE.
- Minimum latency: grant in IDLE cycle 0, AR cycle 1, response pulse cycle 3 with zero-wait slave.
- Re-arbitration occurs in IDLE cycle after the response pulse; master must have deasserted valid by then or is re-granted (master's responsibility).
- mem_araddr/mem_awaddr hold stable while valid; requester address changes after grant do not affect the transaction.
- mem_rvalid in AR (before arready) ignored; mem_bvalid before both AW/W done ignored.

Optional Feature:
YSYX_BUS_ARB_RR_EN: defined -> round-robin between IFU and LSU: owner register records last grant; in IDLE, if both masters request, the one not granted last wins (LSU write still precedes LSU read within LSU). Undefined -> fixed priority above; IFU can starve under continuous LSU traffic.

Test Plan:
- IFU only, zero-wait slave, ifu_araddr=0x80000000, mem_rdata=0x00000413 -> mem_arvalid cycle 1, ifu_rvalid=1 cycle 3 with ifu_rdata=0x00000413, lsu_rvalid=0.
- Same-cycle IFU read 0x80000004 and LSU read 0x80001000 -> LSU served first (mem_araddr=0x80001000), then IFU; RR_EN with last owner=LSU -> IFU first.
- LSU write 0x80002000 data 0xDEADBEEF wstrb 0xF, awready 2 cycles before wready -> mem_awvalid drops after awready, mem_wvalid held until wready, one lsu_bvalid pulse after mem_bvalid.
- Slave inserts 5-cycle arready and 3-cycle rvalid delay -> mem_araddr stable throughout, exactly one ifu_rvalid pulse.
- rst driven 0 while in R state -> next cycle IDLE, all valids 0; later mem_rvalid produces no rvalid pulse.
- Back-to-back IFU requests held high -> grant, response, IDLE, re-grant: one transaction per response, no duplicate pulses.
